// File: rtl/regfile_param.sv
// Parametrised register file with two bypassed read ports, a general write port,
// a dedicated program-counter write port on the top register and a busy scoreboard.
module regfile_param #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic             rd_busy1,
    output logic             rd_busy2,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pc_wr_en,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr
);

    localparam logic [AW-1:0] PC_IDX = AW'(DEPTH - 1);

    generate
        if (DEPTH < 2 || DEPTH != (1 << AW)) begin : g_bad_params
            $error("regfile_param: DEPTH must be a power of 2 (>= 2) equal to 2**AW");
        end
    endgenerate

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;

    logic byp1;
    logic byp2;

    // The general write is placed after the PC write so a same-cycle
    // writeback to PC_IDX overrides pc_in (branch/jump-register result wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (pc_wr_en) begin
                regs[PC_IDX] <= pc_in;
            end
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            // A new producer issued in the same cycle as a writeback keeps the bit set.
            if (issue_en && (issue_addr != PC_IDX)) begin
                busy[issue_addr] <= 1'b1;
            end
        end
    end

    assign byp1 = wr_en && (wr_addr == rd_addr1);
    assign byp2 = wr_en && (wr_addr == rd_addr2);

    assign rd_data1 = byp1 ? wr_data : regs[rd_addr1];
    assign rd_data2 = byp2 ? wr_data : regs[rd_addr2];

    assign rd_busy1 = busy[rd_addr1] & ~byp1;
    assign rd_busy2 = busy[rd_addr2] & ~byp2;

    assign pc_out = regs[PC_IDX];

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios plus randomized traffic
// checked against an array-based reference model; a second 32x16 instance covers widths.
module tb_regfile_param;

    logic        clk;
    logic        reset;
    logic [2:0]  rd_addr1, rd_addr2, wr_addr, issue_addr;
    logic [15:0] rd_data1, rd_data2, wr_data, pc_in, pc_out;
    logic        rd_busy1, rd_busy2, wr_en, pc_wr_en, issue_en;

    logic        w_reset;
    logic [3:0]  w_rd_addr1, w_rd_addr2, w_wr_addr, w_issue_addr;
    logic [31:0] w_rd_data1, w_rd_data2, w_wr_data, w_pc_in, w_pc_out;
    logic        w_rd_busy1, w_rd_busy2, w_wr_en, w_pc_wr_en, w_issue_en;

    int errors = 0;
    int checks = 0;

    logic [15:0] model_regs [8];
    bit          model_busy [8];

    regfile_param dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pc_wr_en(pc_wr_en), .pc_in(pc_in), .pc_out(pc_out),
        .issue_en(issue_en), .issue_addr(issue_addr)
    );

    regfile_param #(.WIDTH(32), .DEPTH(16), .AW(4)) dut_wide (
        .clk(clk), .reset(w_reset),
        .rd_addr1(w_rd_addr1), .rd_addr2(w_rd_addr2),
        .rd_data1(w_rd_data1), .rd_data2(w_rd_data2),
        .rd_busy1(w_rd_busy1), .rd_busy2(w_rd_busy2),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .pc_wr_en(w_pc_wr_en), .pc_in(w_pc_in), .pc_out(w_pc_out),
        .issue_en(w_issue_en), .issue_addr(w_issue_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour at a clock edge: reset clears everything, otherwise
    // PC port first, general port overrides it, issue (not to PC) beats a clear.
    task automatic model_next();
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                model_regs[i] = '0;
                model_busy[i] = 1'b0;
            end
        end else begin
            if (pc_wr_en) model_regs[7] = pc_in;
            if (wr_en) begin
                model_regs[wr_addr] = wr_data;
                model_busy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 3'd7) model_busy[issue_addr] = 1'b1;
        end
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        reset = 0; wr_en = 0; pc_wr_en = 0; issue_en = 0;
        wr_addr = 0; wr_data = 0; pc_in = 0; issue_addr = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1;
        step();
        reset = 0;
        for (int a = 0; a < 8; a++) begin
            rd_addr1 = 3'(a);
            rd_addr2 = 3'(7 - a);
            #1;
            checks++;
            if (rd_data1 !== 16'h0000 || rd_data2 !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL reset_data addr=%0d: got %h/%h, want 0000/0000", a, rd_data1, rd_data2);
            end
            checks++;
            if (rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_busy addr=%0d: got %b/%b, want 0/0", a, rd_busy1, rd_busy2);
            end
        end
        checks++;
        if (pc_out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_pc: got %h, want 0000", pc_out);
        end
    endtask

    task automatic test_bypass();
        drive_idle();
        wr_en = 1; wr_addr = 3; wr_data = 16'hA5A5;
        rd_addr1 = 3; rd_addr2 = 4;
        #1;
        checks++;
        if (rd_data1 !== 16'hA5A5) begin
            errors++;
            $display("[TB] FAIL bypass_same_cycle: got %h, want a5a5", rd_data1);
        end
        checks++;
        if (rd_data2 !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL bypass_other_port: got %h, want 0000", rd_data2);
        end
        step();
        wr_en = 0;
        rd_addr2 = 3;
        #1;
        checks++;
        if (rd_data1 !== 16'hA5A5 || rd_data2 !== 16'hA5A5) begin
            errors++;
            $display("[TB] FAIL write_persist: got %h/%h, want a5a5/a5a5", rd_data1, rd_data2);
        end
    endtask

    task automatic test_pc_priority();
        drive_idle();
        pc_wr_en = 1; pc_in = 16'h0010;
        rd_addr1 = 7;
        #1;
        checks++;
        if (rd_data1 !== 16'h0000 || pc_out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL pc_no_bypass: got rd=%h pc=%h, want 0000/0000", rd_data1, pc_out);
        end
        step();
        pc_wr_en = 0;
        #1;
        checks++;
        if (pc_out !== 16'h0010 || rd_data1 !== 16'h0010) begin
            errors++;
            $display("[TB] FAIL pc_write: got pc=%h rd=%h, want 0010/0010", pc_out, rd_data1);
        end
        pc_wr_en = 1; pc_in = 16'h0012;
        wr_en = 1; wr_addr = 7; wr_data = 16'h0100;
        #1;
        checks++;
        if (pc_out !== 16'h0010 || rd_data1 !== 16'h0100) begin
            errors++;
            $display("[TB] FAIL pc_out_unbypassed: got pc=%h rd=%h, want 0010/0100", pc_out, rd_data1);
        end
        step();
        drive_idle();
        #1;
        checks++;
        if (pc_out !== 16'h0100) begin
            errors++;
            $display("[TB] FAIL pc_priority: got %h, want 0100", pc_out);
        end
    endtask

    task automatic test_scoreboard();
        drive_idle();
        issue_en = 1; issue_addr = 2;
        rd_addr1 = 2;
        step();
        issue_en = 0;
        #1;
        checks++;
        if (rd_busy1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL issue_sets_busy: got %b, want 1", rd_busy1);
        end
        wr_en = 1; wr_addr = 2; wr_data = 16'h2222;
        #1;
        checks++;
        if (rd_busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_bypass: got %b, want 0", rd_busy1);
        end
        step();
        wr_en = 0;
        #1;
        checks++;
        if (rd_busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL writeback_clears: got %b, want 0", rd_busy1);
        end
        issue_en = 1; issue_addr = 5;
        wr_en = 1; wr_addr = 5; wr_data = 16'h5555;
        step();
        drive_idle();
        rd_addr2 = 5;
        #1;
        checks++;
        if (rd_busy2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL issue_beats_clear: got %b, want 1", rd_busy2);
        end
        // A second issue must not count up: one writeback clears it.
        issue_en = 1; issue_addr = 5;
        step();
        issue_en = 0;
        wr_en = 1; wr_addr = 5; wr_data = 16'h5A5A;
        step();
        wr_en = 0;
        #1;
        checks++;
        if (rd_busy2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_bit_busy: got %b, want 0", rd_busy2);
        end
        issue_en = 1; issue_addr = 7;
        rd_addr1 = 7;
        step();
        issue_en = 0;
        #1;
        checks++;
        if (rd_busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pc_never_busy: got %b, want 0", rd_busy1);
        end
    endtask

    task automatic test_reset_midop();
        drive_idle();
        wr_en = 1; wr_addr = 4; wr_data = 16'h1234;
        issue_en = 1; issue_addr = 4;
        step();
        drive_idle();
        rd_addr1 = 4;
        #1;
        checks++;
        if (rd_data1 !== 16'h1234 || rd_busy1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midop_setup: got %h/%b, want 1234/1", rd_data1, rd_busy1);
        end
        reset = 1;
        wr_en = 1; wr_addr = 4; wr_data = 16'hFFFF;
        pc_wr_en = 1; pc_in = 16'hBEEF;
        issue_en = 1; issue_addr = 4;
        step();
        drive_idle();
        #1;
        checks++;
        if (rd_data1 !== 16'h0000 || rd_busy1 !== 1'b0 || pc_out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_overrides: got %h/%b pc=%h, want 0000/0/0000", rd_data1, rd_busy1, pc_out);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp1, exp2;
        logic        expb1, expb2;
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 40) == 0);
            wr_en      = $urandom_range(0, 1);
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = 16'($urandom);
            pc_wr_en   = ($urandom_range(0, 3) == 0);
            pc_in      = 16'($urandom);
            issue_en   = $urandom_range(0, 1);
            issue_addr = 3'($urandom_range(0, 7));
            rd_addr1   = 3'($urandom_range(0, 7));
            rd_addr2   = ($urandom_range(0, 3) == 0) ? rd_addr1 : 3'($urandom_range(0, 7));
            #1;
            exp1  = (wr_en && wr_addr == rd_addr1) ? wr_data : model_regs[rd_addr1];
            exp2  = (wr_en && wr_addr == rd_addr2) ? wr_data : model_regs[rd_addr2];
            expb1 = model_busy[rd_addr1] && !(wr_en && wr_addr == rd_addr1);
            expb2 = model_busy[rd_addr2] && !(wr_en && wr_addr == rd_addr2);
            checks++;
            if (rd_data1 !== exp1 || rd_data2 !== exp2) begin
                errors++;
                $display("[TB] FAIL rand_data n=%0d: got %h/%h, want %h/%h", n, rd_data1, rd_data2, exp1, exp2);
            end
            checks++;
            if (rd_busy1 !== expb1 || rd_busy2 !== expb2) begin
                errors++;
                $display("[TB] FAIL rand_busy n=%0d: got %b/%b, want %b/%b", n, rd_busy1, rd_busy2, expb1, expb2);
            end
            checks++;
            if (pc_out !== model_regs[7]) begin
                errors++;
                $display("[TB] FAIL rand_pc n=%0d: got %h, want %h", n, pc_out, model_regs[7]);
            end
            step();
        end
        drive_idle();
    endtask

    task automatic test_wide();
        w_reset = 1; w_wr_en = 0; w_pc_wr_en = 0; w_issue_en = 0;
        w_wr_addr = 0; w_wr_data = 0; w_pc_in = 0; w_issue_addr = 0;
        w_rd_addr1 = 9; w_rd_addr2 = 15;
        @(posedge clk); #1;
        w_reset = 0;
        w_wr_en = 1; w_wr_addr = 9; w_wr_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (w_rd_data1 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL wide_bypass: got %h, want deadbeef", w_rd_data1);
        end
        @(posedge clk); #1;
        w_wr_en = 0;
        w_pc_wr_en = 1; w_pc_in = 32'h00001000;
        w_issue_en = 1; w_issue_addr = 15;
        @(posedge clk); #1;
        w_pc_wr_en = 0; w_issue_en = 0;
        #1;
        checks++;
        if (w_rd_data1 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL wide_readback: got %h, want deadbeef", w_rd_data1);
        end
        checks++;
        if (w_pc_out !== 32'h00001000 || w_rd_data2 !== 32'h00001000) begin
            errors++;
            $display("[TB] FAIL wide_pc: got pc=%h rd=%h, want 00001000", w_pc_out, w_rd_data2);
        end
        checks++;
        if (w_rd_busy2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wide_pc_not_busy: got %b, want 0", w_rd_busy2);
        end
    endtask

    initial begin
        drive_idle();
        rd_addr1 = 0; rd_addr2 = 0;
        w_reset = 1; w_wr_en = 0; w_pc_wr_en = 0; w_issue_en = 0;
        w_wr_addr = 0; w_wr_data = 0; w_pc_in = 0; w_issue_addr = 0;
        w_rd_addr1 = 0; w_rd_addr2 = 0;
        for (int i = 0; i < 8; i++) begin
            model_regs[i] = '0;
            model_busy[i] = 1'b0;
        end
        @(posedge clk); #1;
        test_reset();
        test_bypass();
        test_pc_priority();
        test_scoreboard();
        test_reset_midop();
        test_random();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised general-purpose register file for the pipelined core.
- Provides two combinational read ports with write-through bypass and one general write port (writeback stage).
- The top register (PC_IDX = DEPTH-1) is the program counter. It has its own dedicated write port.
- A per-register busy scoreboard is set at issue and cleared at writeback. Decode uses it for hazard stalls.

Parameters:
WIDTH, 16, data width of every register in bits
DEPTH, 8, number of registers; must be a power of 2, minimum 2
AW, 3, address width; must equal log2(DEPTH)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
rd_addr1  input  AW  read port 1 address
rd_addr2  input  AW  read port 2 address
rd_data1  output  WIDTH  read port 1 data, combinational
rd_data2  output  WIDTH  read port 2 data, combinational
rd_busy1  output  1  scoreboard bit for rd_addr1, combinational
rd_busy2  output  1  scoreboard bit for rd_addr2, combinational
wr_en  input  1  general write enable, active-high
wr_addr  input  AW  general write address
wr_data  input  WIDTH  general write data
pc_wr_en  input  1  PC write enable, active-high
pc_in  input  WIDTH  next PC value
pc_out  output  WIDTH  current PC (register PC_IDX), straight from flop
issue_en  input  1  mark destination register pending
issue_addr  input  AW  destination register being issued

Behaviour:
- Reset
  - Reset is synchronous and active-high. On a clk edge with reset=1, all DEPTH registers load 0 and all busy bits clear to 0.
  - Reset overrides wr_en, pc_wr_en and issue_en in the same cycle.
  - Resulting output values: pc_out=0. rd_data1/2=0 and rd_busy1/2=0 unless bypass applies.
- General write
  - On a clk edge with wr_en=1, reg[wr_addr] <= wr_data.
  - This includes wr_addr==PC_IDX, which serves jump-register/branch writeback.
- PC write
  - On a clk edge with pc_wr_en=1, reg[PC_IDX] <= pc_in.
  - If wr_en=1 and wr_addr==PC_IDX in the same cycle, wr_data wins and pc_in is dropped.
- Read
  - rd_dataN = (wr_en && wr_addr==rd_addrN) ? wr_data : reg[rd_addrN].
  - There is zero-latency bypass on the general port only. pc_in is never bypassed.
  - pc_out is not bypassed; it always shows the flop value.
- Scoreboard
  - busy[DEPTH] flops.
  - On a clk edge:
    - issue_en=1 sets busy[issue_addr].
    - wr_en=1 clears busy[wr_addr].
  - If issue_en and wr_en target the same address in one cycle, the bit ends SET (the new producer wins).
  - issue_en with issue_addr==PC_IDX is ignored, so busy[PC_IDX] stays 0 permanently.
  - rd_busyN = busy[rd_addrN] & ~(wr_en && wr_addr==rd_addrN). This is consistent with the data bypass.
  - Issuing to an already-busy register keeps it set. This is a single-bit scoreboard, not a counter.
- Other rules
  - Two reads of the same address return identical data.
  - Width: no truncation or extension; all data paths are exactly WIDTH bits.
  - Latency: write to visible-from-flop takes 1 cycle; visible via bypass takes 0 cycles.

Test Plan:
- Reset then read all: assert reset 1 cycle, sweep rd_addr1/2 over 0..7 -> rd_data=0x0000, rd_busy=0, pc_out=0x0000.
- Write/read + bypass: cycle N wr_en=1, wr_addr=3, wr_data=0xA5A5, rd_addr1=3 -> rd_data1=0xA5A5 in cycle N. Cycle N+1 with wr_en=0 -> still 0xA5A5.
- PC priority: pc_wr_en=1, pc_in=0x0010 -> pc_out=0x0010 next cycle. Then pc_wr_en=1, pc_in=0x0012 together with wr_en=1, wr_addr=7, wr_data=0x0100 -> pc_out=0x0100.
- Scoreboard:
  - issue_en, issue_addr=2 -> rd_busy1(addr 2)=1 next cycle.
  - Then wr_en, wr_addr=2 -> rd_busy1=0 in the same cycle (bypass) and remains 0.
  - Simultaneous issue+write to addr 5 -> busy[5]=1 after the edge.
  - issue_addr=7 -> busy[7] stays 0.
- Reset mid-operation: with reg4=0x1234 and busy[4]=1, assert reset together with wr_en=1, wr_addr=4, wr_data=0xFFFF -> reg4=0, busy[4]=0 after the edge.
- Parameter sweep: WIDTH=32, DEPTH=16 -> write 0xDEADBEEF to reg 9 and read back; PC_IDX=15 tracks pc_in=0x00001000.
